// File: rtl/axi4l_to_core_bridge_if.sv
// AXI4-Lite slave-side and Ibex-style core-side bus bundles used by the bridge.
interface axi4l_if;
   logic        aclk;
   logic        aresetn;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport slave (
      input  aclk, aresetn, awaddr, awprot, awvalid, wdata, wstrb, wvalid,
             bready, araddr, arprot, arvalid, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

interface core_if;
   logic        clk;
   logic        rst_n;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output clk, rst_n, req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/axi4l_to_core_bridge.sv
// AXI4-Lite slave to core req/gnt/rvalid master; one transaction in flight, reads win ties.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module axi4l_to_core_bridge (
   axi4l_if.slave     axi,
   core_if.master     core,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ        = 3'd1,
      READ_WAIT0  = 3'd2,
      READ_WAIT1  = 3'd3,
      WRITE       = 3'd4,
      WRITE_WAIT0 = 3'd5,
      WRITE_WAIT1 = 3'd6
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        ar_rdy;
   logic        aw_rdy;
   logic        unused_prot;

   assign unused_prot = ^{axi.awprot, axi.arprot};

   always_ff @(posedge axi.aclk) begin
      if (!axi.aresetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         rresp_q <= '0;
         bresp_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         bresp_q <= bresp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      bresp_d = bresp_q;
      ar_rdy  = 1'b0;
      aw_rdy  = 1'b0;
      case (state_q)
         IDLE: begin
            if (axi.arvalid) begin
               addr_d  = axi.araddr;
               be_d    = 4'hF;
               state_d = READ;
            end else if (axi.awvalid && axi.wvalid) begin
               addr_d  = axi.awaddr;
               wdata_d = axi.wdata;
               be_d    = axi.wstrb;
               state_d = WRITE;
            end
         end
         READ: begin
            // AR completes in the grant cycle, so the master sees the core's acceptance directly.
            ar_rdy = core.gnt;
            if (core.gnt) state_d = READ_WAIT0;
         end
         READ_WAIT0: begin
            if (core.rvalid) begin
               rdata_d = core.rdata;
               rresp_d = core.err ? RESP_SLVERR : RESP_OKAY;
               state_d = READ_WAIT1;
            end
         end
         READ_WAIT1: begin
            if (axi.rready) state_d = IDLE;
         end
         WRITE: begin
            aw_rdy = core.gnt;
            if (core.gnt) state_d = WRITE_WAIT0;
         end
         WRITE_WAIT0: begin
            if (core.rvalid) begin
               bresp_d = core.err ? RESP_SLVERR : RESP_OKAY;
               state_d = WRITE_WAIT1;
            end
         end
         WRITE_WAIT1: begin
            if (axi.bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign core.clk   = axi.aclk;
   assign core.rst_n = axi.aresetn;
   assign core.req   = (state_q == READ) || (state_q == WRITE);
   assign core.we    = (state_q == WRITE);
   assign core.addr  = addr_q;
   assign core.be    = be_q;
   assign core.wdata = wdata_q;

   assign axi.arready = ar_rdy;
   assign axi.awready = aw_rdy;
   assign axi.wready  = aw_rdy;
   assign axi.rvalid  = (state_q == READ_WAIT1);
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.bvalid  = (state_q == WRITE_WAIT1);
   assign axi.bresp   = bresp_q;

   assign state_o = state_q;

endmodule

// File: tb/tb_axi4l_to_core_bridge.sv
// Bench for axi4l_to_core_bridge: AXI master tasks, a core responder with memory, and scoreboards.
module tb_axi4l_to_core_bridge;

  logic clk;
  logic rst_n;
  logic [2:0] state;

  axi4l_if axi_bus ();
  core_if  core_bus ();

  assign axi_bus.aclk    = clk;
  assign axi_bus.aresetn = rst_n;

  axi4l_to_core_bridge dut (
    .axi     (axi_bus),
    .core    (core_bus),
    .state_o (state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_dly = 0;
  int rsp_dly = 0;
  bit err_knob = 0;
  int rd_pushed = 0;
  int wr_pushed = 0;
  int rd_done = 0;
  int wr_done = 0;

  logic [33:0] rd_exp_q[$];
  logic [1:0]  wr_exp_q[$];
  logic [68:0] core_exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] core_mem[logic [31:0]];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic push_rd(input logic [31:0] a);
    core_exp_q.push_back({a, 1'b0, 4'hF, 32'h0});
    rd_exp_q.push_back({(err_knob ? 2'b10 : 2'b00), ref_rd(a)});
    rd_pushed++;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    core_exp_q.push_back({a, 1'b1, s, d});
    wr_exp_q.push_back(err_knob ? 2'b10 : 2'b00);
    if (!err_knob) ref_mem[a] = merge(ref_rd(a), d, s);
    wr_pushed++;
  endtask

  // core-side responder: owns gnt/rvalid/rdata/err, checks every request cycle against the expected head
  initial begin
    int wait_cnt;
    int rsp_cnt;
    bit pend;
    logic [31:0] pend_data;
    logic [68:0] e;
    wait_cnt = 0; rsp_cnt = 0; pend = 0; pend_data = '0;
    core_bus.gnt = 1'b0; core_bus.rvalid = 1'b0; core_bus.rdata = '0; core_bus.err = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      core_bus.gnt = 1'b0;
      core_bus.rvalid = 1'b0;
      core_bus.err = 1'b0;
      if (!rst_n) begin
        pend = 0;
        wait_cnt = 0;
      end else if (pend) begin
        if (rsp_cnt >= rsp_dly) begin
          core_bus.rvalid = 1'b1;
          core_bus.rdata = pend_data;
          core_bus.err = err_knob;
          pend = 0;
        end else rsp_cnt++;
      end else if (core_bus.req) begin
        if (core_exp_q.size() == 0) begin
          check("core_unexpected_req", {68'h0, core_bus.req}, 69'h0);
        end else begin
          e = core_exp_q[0];
          check("core_req_fields",
                {core_bus.addr, core_bus.we, core_bus.be, (core_bus.we ? core_bus.wdata : 32'h0)}, e);
          if (wait_cnt >= gnt_dly) begin
            core_bus.gnt = 1'b1;
            void'(core_exp_q.pop_front());
            wait_cnt = 0;
            pend = 1;
            rsp_cnt = 0;
            if (core_bus.we) begin
              pend_data = $urandom;
              if (!err_knob)
                core_mem[core_bus.addr] = merge(core_mem.exists(core_bus.addr) ? core_mem[core_bus.addr] : 32'h0,
                                                core_bus.wdata, core_bus.be);
            end else begin
              pend_data = core_mem.exists(core_bus.addr) ? core_mem[core_bus.addr] : 32'h0;
            end
          end else wait_cnt++;
        end
      end
    end
  end

  // ready signals only ever appear together with a grant
  always @(negedge clk) begin
    if (rst_n && (axi_bus.arready || axi_bus.awready || axi_bus.wready))
      check("ready_needs_gnt", {67'h0, core_bus.gnt, axi_bus.awready == axi_bus.wready}, 69'h3);
  end

  // driver tasks
  task automatic do_read(input logic [31:0] a, input int rdy_dly, input int exp_lat, input bit push);
    int n;
    int start;
    logic [31:0] d0;
    logic [1:0] r0;
    logic [33:0] e;
    if (push) push_rd(a);
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b1;
    axi_bus.araddr = a;
    start = cyc;
    n = 0;
    while (!axi_bus.arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("ar_timeout", 69'h0, 69'h1);
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b0;
    n = 0;
    while (!axi_bus.rvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("r_timeout", 69'h0, 69'h1);
    if (exp_lat > 0) check("rd_latency", 69'(cyc - start), 69'(exp_lat));
    d0 = axi_bus.rdata;
    r0 = axi_bus.rresp;
    repeat (rdy_dly) begin
      @(negedge clk);
      check("r_hold", {34'h0, axi_bus.rvalid, axi_bus.rdata, axi_bus.rresp, core_bus.req},
            {34'h0, 1'b1, d0, r0, 1'b0});
    end
    @(posedge clk); #1;
    axi_bus.rready = 1'b1;
    @(negedge clk);
    if (rd_exp_q.size() == 0) check("rd_unexpected", 69'h1, 69'h0);
    else begin
      e = rd_exp_q.pop_front();
      check("rdata_rresp", {34'h0, axi_bus.rvalid, axi_bus.rresp, axi_bus.rdata}, {34'h0, 1'b1, e});
    end
    @(posedge clk); #1;
    axi_bus.rready = 1'b0;
    rd_done++;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int rdy_dly, input bit push);
    int n;
    logic [1:0] r0;
    logic [1:0] e;
    if (push) push_wr(a, d, s);
    @(posedge clk); #1;
    axi_bus.awvalid = 1'b1;
    axi_bus.awaddr = a;
    axi_bus.wvalid = 1'b1;
    axi_bus.wdata = d;
    axi_bus.wstrb = s;
    n = 0;
    while (!(axi_bus.awready && axi_bus.wready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("aw_timeout", 69'h0, 69'h1);
    @(posedge clk); #1;
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid = 1'b0;
    n = 0;
    while (!axi_bus.bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("b_timeout", 69'h0, 69'h1);
    r0 = axi_bus.bresp;
    repeat (rdy_dly) begin
      @(negedge clk);
      check("b_hold", {65'h0, axi_bus.bvalid, axi_bus.bresp, core_bus.req}, {65'h0, 1'b1, r0, 1'b0});
    end
    @(posedge clk); #1;
    axi_bus.bready = 1'b1;
    @(negedge clk);
    if (wr_exp_q.size() == 0) check("wr_unexpected", 69'h1, 69'h0);
    else begin
      e = wr_exp_q.pop_front();
      check("bresp", {66'h0, axi_bus.bvalid, axi_bus.bresp}, {66'h0, 1'b1, e});
    end
    @(posedge clk); #1;
    axi_bus.bready = 1'b0;
    wr_done++;
  endtask

  initial begin
    logic [31:0] wd[5];
    int n;
    rst_n = 1'b0;
    axi_bus.awaddr = '0; axi_bus.awprot = '0; axi_bus.awvalid = 1'b0;
    axi_bus.wdata = '0; axi_bus.wstrb = '0; axi_bus.wvalid = 1'b0; axi_bus.bready = 1'b0;
    axi_bus.araddr = '0; axi_bus.arprot = '0; axi_bus.arvalid = 1'b0; axi_bus.rready = 1'b0;
    core_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {66'h0, state}, 69'h0);
    check("reset_outputs", {61'h0, core_bus.req, axi_bus.rvalid, axi_bus.bvalid, axi_bus.arready,
                            axi_bus.awready, axi_bus.wready, 2'b00}, 69'h0);
    check("reset_regs", {33'h0, axi_bus.rdata, axi_bus.rresp, axi_bus.bresp}, 69'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // read with immediate grant, minimum latency
    gnt_dly = 0;
    do_read(32'h100, 0, 3, 1);

    // write with grant delayed 3 cycles, partial strobe
    gnt_dly = 3;
    do_write(32'h40, 32'h12345678, 4'b0011, 0, 1);
    gnt_dly = 0;
    do_read(32'h40, 0, 0, 1);

    // error responses
    err_knob = 1;
    do_read(32'h100, 0, 0, 1);
    do_write(32'h300, 32'hCAFEF00D, 4'hF, 0, 1);
    err_knob = 0;

    // backpressure on R and B
    do_write(32'h44, 32'hA5A5_5A5A, 4'b1100, 4, 1);
    do_read(32'h44, 4, 0, 1);

    // simultaneous read and write: read must reach the core first
    push_rd(32'h100);
    push_wr(32'h48, 32'h0BADF00D, 4'hF);
    fork
      do_read(32'h100, 0, 0, 0);
      do_write(32'h48, 32'h0BADF00D, 4'hF, 0, 0);
    join

    // five writes then five reads back-to-back
    for (int i = 0; i < 5; i++) wd[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      gnt_dly = $urandom_range(0, 2);
      do_write(32'h200 + 32'(4 * i), wd[i], 4'hF, $urandom_range(0, 2), 1);
    end
    for (int i = 0; i < 5; i++) begin
      gnt_dly = $urandom_range(0, 2);
      do_read(32'h200 + 32'(4 * i), $urandom_range(0, 2), 0, 1);
    end
    gnt_dly = 0;

    // reset while waiting for the core response
    rsp_dly = 3;
    core_exp_q.push_back({32'h104, 1'b0, 4'hF, 32'h0});
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b1;
    axi_bus.araddr = 32'h104;
    n = 0;
    while (!axi_bus.arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("abort_ar_timeout", 69'h0, 69'h1);
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_wait0", {66'h0, state}, 69'h2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", {64'h0, state, core_bus.req, axi_bus.rvalid}, {64'h0, 3'd0, 1'b0, 1'b0});
    rsp_dly = 0;
    do_read(32'h100, 0, 3, 1);

    repeat (3) @(posedge clk);
    check("rd_count", 69'(rd_done), 69'(rd_pushed));
    check("wr_count", 69'(wr_done), 69'(wr_pushed));
    check("queues_empty", 69'(rd_exp_q.size() + wr_exp_q.size() + core_exp_q.size()), 69'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
